// File: rtl/gpr_mp_sb.sv
// Multi-port general register file with two forwarding write ports and a
// per-register scoreboard of outstanding long-latency producers.
module gpr_mp_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 3,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wr_addr0,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wr_addr1,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    input  logic                     sb_flush
);

    logic [DATA_W-1:0]  regs_q [REG_NUM];
    logic [DATA_W-1:0]  regs_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic [ADDR_W-1:0]  rd_addr_a [NUM_RD];
    logic               wr0_en;
    logic               wr1_en;
    logic               sb_en;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_addr
        assign rd_addr_a[k] = rd_addr[k*ADDR_W +: ADDR_W];
    end

    // Register 0 swallows writes and sets when it is hardwired to zero.
    assign wr0_en = we0    && !(ZERO_REG && wr_addr0 == '0);
    assign wr1_en = we1    && !(ZERO_REG && wr_addr1 == '0);
    assign sb_en  = sb_set && !(ZERO_REG && sb_addr  == '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is inferred.
        regs_d = regs_q;
        if (reset) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs_d[r] = '0;
            end
        end else begin
            if (wr0_en) regs_d[wr_addr0] = wr_data0;
            // Port 1 is applied last so it wins a same-address collision.
            if (wr1_en) regs_d[wr_addr1] = wr_data1;
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < REG_NUM; r++) begin
            if (reset || sb_flush) begin
                busy_d[r] = 1'b0;
            end else if (sb_en && sb_addr == ADDR_W'(r)) begin
                // A new producer issued this cycle outranks the write that retires the old one.
                busy_d[r] = 1'b1;
            end else if ((wr0_en && wr_addr0 == ADDR_W'(r)) ||
                         (wr1_en && wr_addr1 == ADDR_W'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // NOTE: the register array is reset explicitly, so it must be built from flops rather than a RAM macro without a clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        regs_q <= regs_d;
        busy_q <= busy_d;
    end

    // Read ports: zero register, then port-1 forward, port-0 forward, array.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (reset || (ZERO_REG && rd_addr_a[k] == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end else if (we1 && wr_addr1 == rd_addr_a[k]) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data1;
                rd_busy[k]                  = 1'b0;
            end else if (we0 && wr_addr0 == rd_addr_a[k]) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data0;
                rd_busy[k]                  = 1'b0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr_a[k]];
                rd_busy[k]                  = busy_q[rd_addr_a[k]];
            end
        end
    end

endmodule

// File: doc/gpr_mp_sb.md
Name: gpr_mp_sb

Overview:
- Parametrised multi-port general register file with an integrated scoreboard; next generation of the core GPR.
- NUM_RD combinational read ports, two synchronous write ports with same-cycle write-to-read forwarding, and an optional hardwired zero register.
- Per-register busy bits track outstanding long-latency producers, so decode can stall on operands without a separate hazard unit.
- Sits between decode (reads, busy check, scoreboard set) and writeback (two write ports: ALU and load/MUL).

Parameters:
- DATA_W, 32, register width in bits
- REG_NUM, 32, number of registers; power of two, >= 2
- ADDR_W, 5, register address width; equals log2(REG_NUM)
- NUM_RD, 3, number of read ports, 1..8
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous reset, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k operand has an outstanding producer
- we0  in  1  write port 0 enable, active-high
- wr_addr0  in  ADDR_W  write port 0 address
- wr_data0  in  DATA_W  write port 0 data
- we1  in  1  write port 1 enable, active-high
- wr_addr1  in  ADDR_W  write port 1 address
- wr_data1  in  DATA_W  write port 1 data
- sb_set  in  1  mark register sb_addr busy
- sb_addr  in  ADDR_W  scoreboard set address
- sb_flush  in  1  clear all busy bits (pipeline flush)

Behaviour:
- Reset, synchronous, active-high: on the first rising edge with reset=1, all registers become 0 and all busy bits become 0.
- While reset=1, all write, set and flush inputs are ignored; rd_data is all 0 and rd_busy is all 0.
- Writes: on a clock edge with weN=1, reg[wr_addrN] <= wr_dataN.
  - The value is visible from the array in the next cycle.
  - If both ports write the same address, port 1 wins.
- Reads are combinational, zero latency. Priority per port k:
  1. ZERO_REG && addr==0 -> 0
  2. we1 && wr_addr1==addr -> wr_data1
  3. we0 && wr_addr0==addr -> wr_data0
  4. otherwise reg[addr]
- Busy bits, next-state order per register r:
  1. sb_flush -> 0
  2. sb_set && sb_addr==r -> 1
  3. (we0 && wr_addr0==r) || (we1 && wr_addr1==r) -> 0
  4. otherwise hold
  - Set and write-clear of the same register in one cycle leaves it busy: the new producer wins.
  - Flush and set in the same cycle: flush wins, and the set is dropped.
- rd_busy[k] = busy[addr_k], except:
  - It is 0 if a write to addr_k is present this cycle (the operand is forwarded).
  - It is 0 for register 0 when ZERO_REG=1.
  - A same-cycle sb_set does not affect rd_busy until the next cycle.
- ZERO_REG=1: writes and sets to register 0 are discarded, and reg[0] stays 0.
- Any rd_addr value in 0..REG_NUM-1 is legal. There is no out-of-range case because REG_NUM = 2^ADDR_W.
- All ports are fully independent: simultaneous reads of the same address on all ports return identical data.

Test Plan:
- Reset, then read all registers on every port -> rd_data=0 and rd_busy=0 everywhere. Write r5=0xDEADBEEF with reset=1 -> r5 still reads 0 after reset drops.
- Forwarding: we0 writes r3=0x11, we1 writes r3=0x22 in the same cycle, and port 0 reads r3 -> rd_data=0x22 that cycle. Next cycle, with no writes, r3 reads 0x22.
- Zero register: we0 writes r0=0xFFFFFFFF and sb_set targets r0 -> r0 reads 0 and rd_busy=0 in all following cycles. With ZERO_REG=0, r0 reads 0xFFFFFFFF.
- Scoreboard: sb_set r7 -> next cycle, a read of r7 shows rd_busy=1. we1 writes r7=0x5A -> that same cycle rd_busy=0 and rd_data=0x5A; the next cycle still shows rd_busy=0.
- Simultaneous events:
  - sb_set r9 together with a we0 write to r9 -> r9 is busy next cycle and holds the new data.
  - sb_flush together with sb_set r4 -> no register is busy next cycle.
- Parameter sweep: NUM_RD=1/4/8 with DATA_W=16/64 and REG_NUM=16/64, using random traffic checked against a reference model for data and busy bits every cycle.
